// File: rtl/pkt_filter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_filter_ctrl
//  Purpose  : Per-port RX packet sequencer. Latches the rule matcher verdict
//             on the first beat of each packet, then forwards or silently
//             drops the whole packet through a one-stage registered AXI-stream
//             output with full back-pressure. Owns the active filter
//             configuration (host updates take effect only at packet
//             boundaries) and keeps saturating pass/drop packet counters.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             s_axis_*                   - RX stream in (from CMAC adapter)
//             m_axis_*                   - C2H stream out (registered)
//             match_in                   - matcher verdict for current beat
//             cfg_rule/ip/port, cfg_update, cfg_pending - config shadow
//             act_rule/ip/port           - active config, to the matcher
//             cnt_clear, pass_cnt, drop_cnt - statistics
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_filter_ctrl #(
    parameter int DATA_W = 512,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic [15:0]           s_axis_tuser_size,
    input  logic [15:0]           s_axis_tuser_src,
    input  logic [15:0]           s_axis_tuser_dst,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [15:0]           m_axis_tuser_size,
    output logic [15:0]           m_axis_tuser_src,
    output logic [15:0]           m_axis_tuser_dst,
    input  logic                  m_axis_tready,
    input  logic                  match_in,
    input  logic [1:0]            cfg_rule,
    input  logic [31:0]           cfg_ip,
    input  logic [31:0]           cfg_port,
    input  logic                  cfg_update,
    output logic [1:0]            act_rule,
    output logic [31:0]           act_ip,
    output logic [31:0]           act_port,
    output logic                  cfg_pending,
    input  logic                  cnt_clear,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                r_state;

    logic                  r_m_tvalid;
    logic [DATA_W-1:0]     r_m_tdata;
    logic [DATA_W/8-1:0]   r_m_tkeep;
    logic                  r_m_tlast;
    logic [15:0]           r_m_size;
    logic [15:0]           r_m_src;
    logic [15:0]           r_m_dst;

    logic [1:0]            r_shadow_rule;
    logic [31:0]           r_shadow_ip;
    logic [31:0]           r_shadow_port;
    logic                  r_pending;
    logic [1:0]            r_act_rule;
    logic [31:0]           r_act_ip;
    logic [31:0]           r_act_port;

    logic [CNT_W-1:0]      r_pass_cnt;
    logic [CNT_W-1:0]      r_drop_cnt;

    logic                  w_can_load;
    logic                  w_tready;
    logic                  w_acc;
    logic                  w_sop_pass;
    logic                  w_sop_drop;
    logic                  w_load;
    logic                  w_apply;

    // The output register may take a new beat when empty or draining now.
    assign w_can_load = ~r_m_tvalid | m_axis_tready;

    // A dropped SOP never needs the output register, so a drop verdict is
    // accepted even while the output is stalled.
    always_comb begin
        w_tready = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: w_tready = match_in ? w_can_load : 1'b1;
                ST_FWD:  w_tready = w_can_load;
                ST_DROP: w_tready = 1'b1;
                default: w_tready = 1'b0;
            endcase
        end
    end

    assign w_acc      = s_axis_tvalid & w_tready;
    assign w_sop_pass = w_acc & (r_state == ST_IDLE) & match_in;
    assign w_sop_drop = w_acc & (r_state == ST_IDLE) & ~match_in;
    assign w_load     = w_sop_pass | (w_acc & (r_state == ST_FWD));

    // Config may only switch outside a packet: idle with nothing arriving,
    // or on the cycle the final beat of a packet is taken.
    assign w_apply = r_pending &
                     (((r_state == ST_IDLE) & ~w_acc) | (w_acc & s_axis_tlast));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (w_acc) begin
            case (r_state)
                ST_IDLE: begin
                    if (s_axis_tlast)  r_state <= ST_IDLE;
                    else if (match_in) r_state <= ST_FWD;
                    else               r_state <= ST_DROP;
                end
                ST_FWD:  if (s_axis_tlast) r_state <= ST_IDLE;
                ST_DROP: if (s_axis_tlast) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------ output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_size   <= '0;
            r_m_src    <= '0;
            r_m_dst    <= '0;
        end else if (w_load) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= s_axis_tdata;
            r_m_tkeep  <= s_axis_tkeep;
            r_m_tlast  <= s_axis_tlast;
            r_m_size   <= s_axis_tuser_size;
            r_m_src    <= s_axis_tuser_src;
            r_m_dst    <= s_axis_tuser_dst;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    // -------------------------------------------------------- configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_rule <= '0;
            r_shadow_ip   <= '0;
            r_shadow_port <= '0;
            r_pending     <= 1'b0;
            r_act_rule    <= '0;
            r_act_ip      <= '0;
            r_act_port    <= '0;
        end else begin
            // Apply uses the shadow as it stood before any same-cycle update.
            if (w_apply) begin
                r_act_rule <= r_shadow_rule;
                r_act_ip   <= r_shadow_ip;
                r_act_port <= r_shadow_port;
            end
            if (cfg_update) begin
                r_shadow_rule <= cfg_rule;
                r_shadow_ip   <= cfg_ip;
                r_shadow_port <= cfg_port;
                r_pending     <= 1'b1;
            end else if (w_apply) begin
                r_pending     <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (cnt_clear) begin
            r_pass_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_sop_pass && (r_pass_cnt != c_CNT_MAX))
                r_pass_cnt <= r_pass_cnt + c_CNT_ONE;
            if (w_sop_drop && (r_drop_cnt != c_CNT_MAX))
                r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
        end
    end

    assign s_axis_tready     = w_tready;
    assign m_axis_tvalid     = r_m_tvalid;
    assign m_axis_tdata      = r_m_tdata;
    assign m_axis_tkeep      = r_m_tkeep;
    assign m_axis_tlast      = r_m_tlast;
    assign m_axis_tuser_size = r_m_size;
    assign m_axis_tuser_src  = r_m_src;
    assign m_axis_tuser_dst  = r_m_dst;
    assign act_rule          = r_act_rule;
    assign act_ip            = r_act_ip;
    assign act_port          = r_act_port;
    assign cfg_pending       = r_pending;
    assign pass_cnt          = r_pass_cnt;
    assign drop_cnt          = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pkt_filter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pkt_filter_ctrl
//  Purpose  : Self-checking bench for pkt_filter_ctrl. Packet table plus
//             hand-written sequences; forwarded beats go through a scoreboard
//             queue checked by an output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_filter_ctrl;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_axis_tvalid;
    logic [DATA_W-1:0] s_axis_tdata;
    logic [7:0]        s_axis_tkeep;
    logic              s_axis_tlast;
    logic [15:0]       s_axis_tuser_size, s_axis_tuser_src, s_axis_tuser_dst;
    logic              s_axis_tready;
    logic              m_axis_tvalid;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [7:0]        m_axis_tkeep;
    logic              m_axis_tlast;
    logic [15:0]       m_axis_tuser_size, m_axis_tuser_src, m_axis_tuser_dst;
    logic              m_axis_tready;
    logic              match_in;
    logic [1:0]        cfg_rule;
    logic [31:0]       cfg_ip, cfg_port;
    logic              cfg_update;
    logic [1:0]        act_rule;
    logic [31:0]       act_ip, act_port;
    logic              cfg_pending;
    logic              cnt_clear;
    logic [CNT_W-1:0]  pass_cnt, drop_cnt;

    pkt_filter_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser_size(s_axis_tuser_size), .s_axis_tuser_src(s_axis_tuser_src),
        .s_axis_tuser_dst(s_axis_tuser_dst), .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser_size(m_axis_tuser_size), .m_axis_tuser_src(m_axis_tuser_src),
        .m_axis_tuser_dst(m_axis_tuser_dst), .m_axis_tready(m_axis_tready),
        .match_in(match_in), .cfg_rule(cfg_rule), .cfg_ip(cfg_ip),
        .cfg_port(cfg_port), .cfg_update(cfg_update), .act_rule(act_rule),
        .act_ip(act_ip), .act_port(act_port), .cfg_pending(cfg_pending),
        .cnt_clear(cnt_clear), .pass_cnt(pass_cnt), .drop_cnt(drop_cnt)
    );

    always #2 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [7:0]        keep;
        logic              last;
        logic [47:0]       user;
        int                ts;
        bit                lat;
    } exp_t;

    typedef struct {
        int nbeats;
        bit m_sop;
        bit m_body;
        int exp_pass;
        int exp_drop;
    } pkt_vec_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic rdy_first;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    // Output monitor: every transferred beat must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got data %h expected none", m_axis_tdata);
            end else begin
                e = q.pop_front();
                chk("out_data", m_axis_tdata, e.data);
                chk("out_keep", {56'd0, m_axis_tkeep}, {56'd0, e.keep});
                chk("out_last", {63'd0, m_axis_tlast}, {63'd0, e.last});
                chk("out_user", {16'd0, m_axis_tuser_size, m_axis_tuser_src, m_axis_tuser_dst},
                    {16'd0, e.user});
                if (e.lat) chk("latency", 64'(cyc), 64'(e.ts));
            end
        end
    end

    task automatic send_beat(input logic last, input logic m, input logic fwd,
                             input logic lat, input logic upd, input logic clr);
        exp_t e;
        logic acc;
        int   waitc;
        e.data = {$urandom(), $urandom()};
        e.keep = 8'($urandom());
        e.last = last;
        e.user = {16'($urandom()), 16'($urandom()), 16'($urandom())};
        s_axis_tdata  = e.data;
        s_axis_tkeep  = e.keep;
        s_axis_tlast  = last;
        {s_axis_tuser_size, s_axis_tuser_src, s_axis_tuser_dst} = e.user;
        s_axis_tvalid = 1'b1;
        match_in      = m;
        cfg_update    = upd;
        cnt_clear     = clr;
        acc   = 1'b0;
        waitc = 0;
        while (!acc) begin
            @(negedge clk);
            acc = s_axis_tready;
            if (waitc == 0) rdy_first = s_axis_tready;
            @(posedge clk);
            #1;
            cfg_update = 1'b0;
            cnt_clear  = 1'b0;
            waitc++;
            if (!acc && waitc > 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: got no s_axis_tready expected acceptance");
                break;
            end
        end
        if (acc && fwd) begin
            e.ts  = cyc;
            e.lat = lat;
            q.push_back(e);
        end
        s_axis_tvalid = 1'b0;
        match_in      = 1'b0;
    endtask

    task automatic send_pkt(input int n, input bit msop, input bit mbody, input bit lat);
        for (int i = 0; i < n; i++) begin
            send_beat(i == n - 1, (i == 0) ? msop : mbody, msop, lat, 1'b0, 1'b0);
            if (!msop) chk("drop_tready", {63'd0, rdy_first}, 64'd1);
        end
    endtask

    task automatic pulse_clear();
        cnt_clear = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
    endtask

    pkt_vec_t vecs[6];

    initial begin
        logic [DATA_W-1:0] held_data;
        logic [7:0]        held_keep;
        logic              held_last;

        vecs[0] = '{3, 1'b1, 1'b1, 1, 0};
        vecs[1] = '{4, 1'b0, 1'b1, 1, 1};
        vecs[2] = '{1, 1'b1, 1'b0, 2, 1};
        vecs[3] = '{2, 1'b0, 1'b0, 2, 2};
        vecs[4] = '{5, 1'b1, 1'b0, 3, 2};
        vecs[5] = '{1, 1'b0, 1'b1, 3, 3};

        rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0; s_axis_tuser_size = '0; s_axis_tuser_src = '0;
        s_axis_tuser_dst = '0; m_axis_tready = 1'b1; match_in = 1'b0;
        cfg_rule = '0; cfg_ip = '0; cfg_port = '0; cfg_update = 1'b0; cnt_clear = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_tready", {63'd0, s_axis_tready}, 64'd0);
        chk("rst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_act_rule", {62'd0, act_rule}, 64'd0);
        chk("rst_pending",  {63'd0, cfg_pending}, 64'd0);
        chk("rst_counts",   {56'd0, pass_cnt, drop_cnt}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven packets, output always ready
        for (int i = 0; i < 6; i++) begin
            send_pkt(vecs[i].nbeats, vecs[i].m_sop, vecs[i].m_body, 1'b1);
            chk("tbl_pass", 64'(pass_cnt), 64'(vecs[i].exp_pass));
            chk("tbl_drop", 64'(drop_cnt), 64'(vecs[i].exp_drop));
        end

        // Back-pressure: stall output for 5 cycles inside a forwarded packet
        send_beat(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        m_axis_tready = 1'b0;
        fork
            send_beat(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            begin
                @(negedge clk);
                held_data = m_axis_tdata;
                held_keep = m_axis_tkeep;
                held_last = m_axis_tlast;
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("stall_s_tready", {63'd0, s_axis_tready}, 64'd0);
                    chk("stall_m_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
                    chk("stall_data", m_axis_tdata, held_data);
                    chk("stall_keep_last", {55'd0, m_axis_tkeep, m_axis_tlast},
                        {55'd0, held_keep, held_last});
                end
                @(posedge clk);
                #2 m_axis_tready = 1'b1;
            end
        join
        send_beat(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_pass", 64'(pass_cnt), 64'd4);

        // Config update on beat 2 of a 5-beat packet
        cfg_rule = 2'b01; cfg_ip = 32'h0A00_0001; cfg_port = 32'h0000_1234;
        send_beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("cfg_hold_rule", {62'd0, act_rule}, 64'd0);
            chk("cfg_hold_pend", {63'd0, cfg_pending}, 64'd1);
            send_beat(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("cfg_hold_rule", {62'd0, act_rule}, 64'd0);
        send_beat(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("cfg_act_rule", {62'd0, act_rule}, 64'd1);
        chk("cfg_act_ip",   {32'd0, act_ip}, 64'h0A00_0001);
        chk("cfg_act_port", {32'd0, act_port}, 64'h1234);
        chk("cfg_pend_clr", {63'd0, cfg_pending}, 64'd0);

        // Back-to-back single-beat packets, alternating verdict
        pulse_clear();
        for (int i = 0; i < 8; i++) send_pkt(1, (i % 2) == 0, 1'b0, 1'b1);
        chk("alt_pass", 64'(pass_cnt), 64'd4);
        chk("alt_drop", 64'(drop_cnt), 64'd4);

        // Saturation, then clear coinciding with a drop
        pulse_clear();
        for (int i = 0; i < 15; i++) send_pkt(1, 1'b1, 1'b0, 1'b1);
        chk("sat_reach", 64'(pass_cnt), 64'd15);
        send_pkt(1, 1'b1, 1'b0, 1'b1);
        chk("sat_hold", 64'(pass_cnt), 64'd15);
        send_beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("clr_drop", 64'(drop_cnt), 64'd0);
        chk("clr_pass", 64'(pass_cnt), 64'd0);

        // Reset in the middle of a forwarded packet
        send_beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("mrst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("mrst_act_rule", {62'd0, act_rule}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_pkt(1, 1'b0, 1'b0, 1'b1);
        chk("mrst_sop_drop", 64'(drop_cnt), 64'd1);
        chk("mrst_sop_pass", 64'(pass_cnt), 64'd0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pkt_filter_ctrl.md
Name: pkt_filter_ctrl

Overview:
Per-port packet sequencer for the 250 MHz user-logic RX filter, sitting between CMAC RX (adapter) and QDMA C2H. It latches the external rule matcher's verdict on the first beat of each packet and then forwards or silently drops the whole packet, through a one-stage registered output with full AXI-stream back-pressure. It also owns the active filter configuration, applying host updates only at packet boundaries, and keeps pass/drop statistics.

Parameters:
DATA_W, 512, tdata width in bits; tkeep width is DATA_W/8
CNT_W, 32, width of the pass/drop statistics counters

Ports:
clk  input  1  250 MHz user clock
rst_n  input  1  asynchronous active-low reset
s_axis_tvalid  input  1  RX beat valid
s_axis_tdata  input  DATA_W  RX beat data
s_axis_tkeep  input  DATA_W/8  RX byte enables
s_axis_tlast  input  1  RX end of packet
s_axis_tuser_size  input  16  packet size sideband
s_axis_tuser_src  input  16  source sideband
s_axis_tuser_dst  input  16  destination sideband
s_axis_tready  output  1  RX ready
m_axis_tvalid  output  1  C2H beat valid (registered)
m_axis_tdata  output  DATA_W  C2H data (registered)
m_axis_tkeep  output  DATA_W/8  C2H byte enables (registered)
m_axis_tlast  output  1  C2H end of packet (registered)
m_axis_tuser_size  output  16  registered size sideband
m_axis_tuser_src  output  16  registered source sideband
m_axis_tuser_dst  output  16  registered destination sideband
m_axis_tready  input  1  C2H ready
match_in  input  1  combinational verdict from the rule matcher for the current s_axis beat
cfg_rule  input  2  requested rule: 01 = IP, 10 = port, others = no match
cfg_ip  input  32  requested IP address
cfg_port  input  32  requested port number
cfg_update  input  1  one-cycle pulse; captures cfg_* into the pending shadow
act_rule  output  2  active rule, to the matcher
act_ip  output  32  active IP, to the matcher
act_port  output  32  active port, to the matcher
cfg_pending  output  1  shadow holds a configuration not yet applied
cnt_clear  input  1  one-cycle pulse; zeroes both counters
pass_cnt  output  CNT_W  packets forwarded
drop_cnt  output  CNT_W  packets dropped

Behaviour:
- Reset values: all m_axis_* outputs 0; s_axis_tready 0 while rst_n is low; act_* 0; cfg_pending 0; counters 0; FSM in IDLE.
- Definitions:
  - acc = s_axis_tvalid & s_axis_tready.
  - can_load = ~m_axis_tvalid | m_axis_tready.
- FSM states:
  - IDLE: awaiting start of packet (SOP).
  - FWD: forwarding packet body.
  - DROP: discarding packet body.
- IDLE:
  - s_axis_tready = match_in ? can_load : 1.
  - On acc with match_in=1: load beat into output register; pass_cnt++; go to FWD unless tlast.
  - On acc with match_in=0: discard beat; drop_cnt++; go to DROP unless tlast.
  - Single-beat packets (tlast on SOP) stay in IDLE.
- FWD:
  - s_axis_tready = can_load.
  - Each acc loads the output register.
  - acc with tlast returns to IDLE.
  - match_in is ignored.
- DROP:
  - s_axis_tready = 1.
  - Beats are discarded.
  - acc with tlast returns to IDLE.
- Output register:
  - m_axis_tvalid is set on load.
  - It is cleared when m_axis_tready=1 and there is no new load that cycle.
  - Payload holds stable while tvalid=1 and tready=0.
  - Forward latency is 1 cycle; full throughput is one beat per cycle with tready held high.
- Configuration:
  - cfg_update captures cfg_* into the shadow and sets cfg_pending.
  - A later update before apply overwrites the shadow (last wins).
  - Apply happens when cfg_pending=1 and either:
    - state=IDLE with no acc this cycle, or
    - an acc with tlast occurs this cycle.
  - On apply, act_* take the shadow on the next edge and cfg_pending clears.
  - If cfg_update and apply coincide, the new value is captured and cfg_pending stays 1; the older shadow value is applied.
  - act_* never change between the SOP beat and the tlast beat of a packet.
- Counters:
  - Both counters saturate at 2^CNT_W-1.
  - cnt_clear has priority over a coincident increment; that event is not counted.
- Reset mid-packet: state and output register are cleared, and the partially output packet is truncated. The next accepted beat is treated as SOP.
- s_axis_tuser_* travel with tdata; only SOP-beat values are meaningful downstream.

Test Plan:
- 3-beat packet, match_in=1 on SOP, m_axis_tready=1 -> 3 beats out, each 1 cycle later, tlast on the 3rd; pass_cnt=1, drop_cnt=0.
- 4-beat packet, match_in=0 on SOP and 1 on beats 2-4 -> no m_axis_tvalid; s_axis_tready=1 throughout; drop_cnt=1.
- Forwarded packet with m_axis_tready=0 for 5 cycles mid-packet -> s_axis_tready low, output beat stable (tdata, tkeep, tlast unchanged), no beat loss or duplication after release.
- cfg_update (rule=01, ip=0x0A000001) on beat 2 of a 5-beat packet -> act_rule stays 00 until the tlast acceptance; act_rule=01 and act_ip=0x0A000001 on the next cycle; cfg_pending then clears.
- Back-to-back single-beat packets with alternating match_in and tready held high -> pass_cnt=drop_cnt=N/2; every forwarded beat carries tlast=1.
- Counter at 0xFFFFFFFF plus a passed packet -> stays 0xFFFFFFFF; cnt_clear in the same cycle as a drop -> drop_cnt=0.
